asc_cola_destinos: RTL and testbench
====================================

Name: asc_cola_destinos

Overview:
- Request queue and dispatcher that sits directly upstream of the elevator car controller.
- Captures floor-call button presses for floors -1, 1, 2 and 3, removes duplicates, and stores them in FIFO order.
- Presents one destination at a time on the controller's 3-bit destino input.
- Hands over the next request only after the controller has dropped ocupado, i.e. the current trip and its door time are finished.

Parameters:
PROFUNDIDAD, 4, FIFO depth in entries; power of two, at least 4. Four entries always suffice because of duplicate removal.
ANCHO_PTR, 2, FIFO pointer width; equals log2(PROFUNDIDAD).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
llamada  input  4  call buttons, active-high level; bit0=-1, bit1=1, bit2=2, bit3=3
piso  input  2  current floor from the controller; 00=-1, 01=1, 10=2, 11=3
ocupado  input  1  controller busy flag
destino  output  3  destination to the controller; bit2=1 means no request, bits[1:0] are the floor code
pendientes  output  4  per-floor pending lamp, one bit per floor, same bit order as llamada
cola_cuenta  output  ANCHO_PTR+1  number of queued entries not yet dispatched

Behaviour:
- Clock and reset are fixed: single clock clk; rst_n asynchronous, active-low. Every register clears on rst_n=0 regardless of clk.
- Reset values:
  - pendientes = 0, cola_cuenta = 0, FIFO pointers = 0, FSM = VACIO.
  - destino = {1'b1, piso}.
  - Reset mid-trip discards every queued and in-service request.
- Floor code equals llamada bit index.
- Edge detection:
  - A 0→1 transition on llamada[i], sampled at cycle N, is a new call.
  - Held levels are ignored.
- Capture (registered):
  - A new call on floor i is dropped when pendientes[i]=1.
  - It is also dropped when FSM=VACIO, ocupado=0 and piso=i (car already at that floor).
  - Otherwise, in cycle N+1, pendientes[i] goes to 1 and the call goes into a staging vector.
- Enqueue:
  - At most one FIFO write per cycle, taken from the staging vector.
  - Lowest set bit wins; its staging bit clears on the write.
  - Simultaneous calls therefore enter on consecutive cycles in order -1, 1, 2, 3.
  - A single call is visible in cola_cuenta at cycle N+2.
- Push and pop in the same cycle are legal; cola_cuenta is unchanged in that case.
- Full and empty:
  - Full is unreachable by construction. Duplicate removal bounds the FIFO to 4 entries, and PROFUNDIDAD is at least 4.
  - A pop while empty never occurs; the FSM gates every pop on cola_cuenta>0.
- destino is combinational from registered state:
  - In VACIO: {1'b1, piso}. Bits[1:0] equal the current floor, so the controller stays idle.
  - In ESPERA and SIRVIENDO: {1'b0, objetivo}.
  - destino is stable for the whole trip.
- FSM states:
  - VACIO:
    - If cola_cuenta>0 and ocupado=0: pop the head h.
    - If h=piso: clear pendientes[h] and stay in VACIO (stale request).
    - Otherwise: objetivo<=h and go to ESPERA. destino changes the next cycle.
  - ESPERA:
    - If ocupado=1, go to SIRVIENDO.
    - If ocupado=0 and piso=objetivo: clear pendientes[objetivo] and go to VACIO.
  - SIRVIENDO:
    - On the cycle ocupado is first sampled 0 (falling edge detected with a registered copy): clear pendientes[objetivo] and go to VACIO.
    - The next request may be popped one cycle later.
- A new call for objetivo while in ESPERA or SIRVIENDO is dropped because its pendientes bit is already 1.
- Worst-case latency from an idle system: call edge at N → destino valid at N+3.

Optional Feature:
- Macro: ASC_LLAMADA_SYNC_EN.
- Defined: llamada passes through a two-flop synchronizer, reset to 0, before edge detection. All call latencies grow by 2 cycles.
- Undefined: llamada is edge-detected directly. Inputs must already be synchronous to clk.

Test Plan:
1. Reset with piso=01 → destino=3'b101, pendientes=0000, cola_cuenta=0. Assert rst_n=0 mid-SIRVIENDO → same values immediately, without waiting for a clk edge.
2. Idle, piso=01, pulse llamada=1000 → pendientes=1000 at N+1, destino=3'b011 at N+3. Model ocupado 1 for 20 cycles then 0 with piso=11 → pendientes=0000, destino=3'b111 one cycle after the fall.
3. Same cycle llamada=0101 while busy toward floor 3 → FIFO order -1 then 2. After ocupado falls, destino=3'b000 first; after the next trip, destino=3'b010.
4. Press llamada[2] three times while it is pending → cola_cuenta stays 1, pendientes[2]=1 only.
5. Idle at piso=10, press llamada[2] → dropped: pendientes=0000, cola_cuenta=0, destino=3'b110.
6. Queue floor 1, force piso=01 before dispatch (stale entry) → entry popped, pendientes[1] cleared, FSM stays VACIO, destino never shows bit2=0.

Source files
------------

// File: rtl/asc_cola_destinos.sv
// ============================================================================
// Module   : asc_cola_destinos
// Purpose  : Floor-call capture, de-duplication and FIFO dispatch of one
//            destination at a time to the elevator car controller.
// Option   : define ASC_LLAMADA_SYNC_EN to add a 2-flop llamada synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module asc_cola_destinos #(
  parameter int PROFUNDIDAD = 4,
  parameter int ANCHO_PTR   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           llamada,
  input  logic [1:0]           piso,
  input  logic                 ocupado,
  output logic [2:0]           destino,
  output logic [3:0]           pendientes,
  output logic [ANCHO_PTR:0]   cola_cuenta
);

  typedef enum logic [1:0] {
    VACIO     = 2'd0,
    ESPERA    = 2'd1,
    SIRVIENDO = 2'd2
  } estado_t;

  logic [3:0] llamada_s;

`ifdef ASC_LLAMADA_SYNC_EN
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = llamada;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign llamada_s = sync2_q;
`else
  assign llamada_s = llamada;
`endif

  estado_t              estado_q, estado_d;
  logic [3:0]           llamada_prev_q, llamada_prev_d;
  logic                 ocupado_prev_q, ocupado_prev_d;
  logic [3:0]           pend_q, pend_d;
  logic [3:0]           stage_q, stage_d;
  logic [1:0]           objetivo_q, objetivo_d;
  logic [1:0]           mem_q [PROFUNDIDAD];
  logic [1:0]           mem_d [PROFUNDIDAD];
  logic [ANCHO_PTR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ANCHO_PTR:0]   count_q, count_d;

  logic [3:0] nueva;
  logic       push, pop;
  logic [1:0] push_code;
  logic [1:0] head;

  always_comb begin
    llamada_prev_d = llamada_s;
    ocupado_prev_d = ocupado;
    nueva          = llamada_s & ~llamada_prev_q;
    pend_d         = pend_q;
    stage_d        = stage_q;
    estado_d       = estado_q;
    objetivo_d     = objetivo_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    push           = 1'b0;
    pop            = 1'b0;
    push_code      = 2'd0;
    head           = mem_q[rd_ptr_q];

    // Single write port: the lowest staged floor enters first.
    for (int i = 3; i >= 0; i--) begin
      if (stage_q[i]) begin
        push      = 1'b1;
        push_code = i[1:0];
      end
    end
    if (push) begin
      stage_d[push_code] = 1'b0;
      mem_d[wr_ptr_q]    = push_code;
      wr_ptr_d           = wr_ptr_q + {{(ANCHO_PTR-1){1'b0}}, 1'b1};
    end

    // A call is already being honoured when pending, or when the idle car sits there.
    for (int i = 0; i < 4; i++) begin
      if (nueva[i] && !pend_q[i] &&
          !(estado_q == VACIO && !ocupado && piso == i[1:0])) begin
        pend_d[i]  = 1'b1;
        stage_d[i] = 1'b1;
      end
    end

    case (estado_q)
      VACIO: begin
        if (count_q != '0 && !ocupado) begin
          pop = 1'b1;
          if (head == piso) begin
            pend_d[head] = 1'b0;
          end else begin
            objetivo_d = head;
            estado_d   = ESPERA;
          end
        end
      end
      ESPERA: begin
        if (ocupado) begin
          estado_d = SIRVIENDO;
        end else if (piso == objetivo_q) begin
          pend_d[objetivo_q] = 1'b0;
          estado_d           = VACIO;
        end
      end
      SIRVIENDO: begin
        if (ocupado_prev_q && !ocupado) begin
          pend_d[objetivo_q] = 1'b0;
          estado_d           = VACIO;
        end
      end
      default: estado_d = VACIO;
    endcase

    if (pop) rd_ptr_d = rd_ptr_q + {{(ANCHO_PTR-1){1'b0}}, 1'b1};

    case ({push, pop})
      2'b10:   count_d = count_q + {{ANCHO_PTR{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{ANCHO_PTR{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= VACIO;
      llamada_prev_q <= '0;
      ocupado_prev_q <= 1'b0;
      pend_q         <= '0;
      stage_q        <= '0;
      objetivo_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      for (int i = 0; i < PROFUNDIDAD; i++) mem_q[i] <= '0;
    end else begin
      estado_q       <= estado_d;
      llamada_prev_q <= llamada_prev_d;
      ocupado_prev_q <= ocupado_prev_d;
      pend_q         <= pend_d;
      stage_q        <= stage_d;
      objetivo_q     <= objetivo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      mem_q          <= mem_d;
    end
  end

  always_comb begin
    destino = {1'b1, piso};
    if (estado_q != VACIO) destino = {1'b0, objetivo_q};
  end

  assign pendientes  = pend_q;
  assign cola_cuenta = count_q;

endmodule

`default_nettype wire

// File: tb/tb_asc_cola_destinos.sv
// ============================================================================
// Module   : tb_asc_cola_destinos
// Purpose  : Scoreboard bench for asc_cola_destinos (default build, no sync).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_asc_cola_destinos;

  logic       clk;
  logic       rst_n;
  logic [3:0] llamada;
  logic [1:0] piso;
  logic       ocupado;
  logic [2:0] destino;
  logic [3:0] pendientes;
  logic [2:0] cola_cuenta;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  asc_cola_destinos #(.PROFUNDIDAD(4), .ANCHO_PTR(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .llamada     (llamada),
    .piso        (piso),
    .ocupado     (ocupado),
    .destino     (destino),
    .pendientes  (pendientes),
    .cola_cuenta (cola_cuenta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drive a one-cycle call pulse; returns at the N+1 observation point.
  task automatic press(input logic [3:0] m);
    llamada = m;
    @(negedge clk);
    llamada = 4'b0000;
  endtask

  task automatic wait_dispatch(input string nm, input int budget);
    int n = 0;
    logic [2:0] e;
    while (destino[2] === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (destino[2] !== 1'b0) begin
      bad++;
      $display("FAIL %s: no dispatch within %0d cycles, destino=%b", nm, budget, destino);
    end else if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected dispatch destino=%b, scoreboard empty", nm, destino);
    end else begin
      e = exp_q.pop_front();
      if (destino !== e) begin
        bad++;
        $display("FAIL %s: destino=%b expected=%b", nm, destino, e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; llamada = 4'b0000; piso = 2'b01; ocupado = 1'b0;
    #3;
    total++; if (destino !== 3'b101) begin bad++; $display("FAIL reset_destino: got %b want 101", destino); end
    total++; if (pendientes !== 4'b0000) begin bad++; $display("FAIL reset_pend: got %b want 0000", pendientes); end
    total++; if (cola_cuenta !== 3'd0) begin bad++; $display("FAIL reset_cuenta: got %0d want 0", cola_cuenta); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_call();
    piso = 2'b01; ocupado = 1'b0;
    press(4'b1000);
    exp_q.push_back(3'b011);
    total++; if (pendientes !== 4'b1000) begin bad++; $display("FAIL single_pend_n1: got %b want 1000", pendientes); end
    total++; if (cola_cuenta !== 3'd0) begin bad++; $display("FAIL single_cuenta_n1: got %0d want 0", cola_cuenta); end
    @(negedge clk);
    total++; if (cola_cuenta !== 3'd1) begin bad++; $display("FAIL single_cuenta_n2: got %0d want 1", cola_cuenta); end
    total++; if (destino !== 3'b101) begin bad++; $display("FAIL single_destino_n2: got %b want 101", destino); end
    @(negedge clk);
    wait_dispatch("single_destino_n3", 0);
    ocupado = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (destino !== 3'b011) begin bad++; $display("FAIL single_trip_destino: got %b want 011", destino); end
    total++; if (pendientes !== 4'b1000) begin bad++; $display("FAIL single_trip_pend: got %b want 1000", pendientes); end
    piso = 2'b11; ocupado = 1'b0;
    @(negedge clk);
    total++; if (destino !== 3'b111) begin bad++; $display("FAIL single_done_destino: got %b want 111", destino); end
    total++; if (pendientes !== 4'b0000) begin bad++; $display("FAIL single_done_pend: got %b want 0000", pendientes); end
  endtask

  task automatic test_fifo_order();
    piso = 2'b01;
    press(4'b1000);
    exp_q.push_back(3'b011);
    wait_dispatch("order_first_trip", 10);
    ocupado = 1'b1;
    repeat (2) @(negedge clk);
    press(4'b0101);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b010);
    total++; if (pendientes !== 4'b1101) begin bad++; $display("FAIL order_pend: got %b want 1101", pendientes); end
    @(negedge clk);
    total++; if (cola_cuenta !== 3'd1) begin bad++; $display("FAIL order_cuenta_n2: got %0d want 1", cola_cuenta); end
    @(negedge clk);
    total++; if (cola_cuenta !== 3'd2) begin bad++; $display("FAIL order_cuenta_n3: got %0d want 2", cola_cuenta); end
    repeat (5) @(negedge clk);
    piso = 2'b11; ocupado = 1'b0;
    @(negedge clk);
    total++; if (destino !== 3'b111) begin bad++; $display("FAIL order_idle_destino: got %b want 111", destino); end
    total++; if (pendientes !== 4'b0101) begin bad++; $display("FAIL order_idle_pend: got %b want 0101", pendientes); end
    wait_dispatch("order_dispatch_m1", 10);
    ocupado = 1'b1;
    repeat (3) @(negedge clk);
    piso = 2'b00; ocupado = 1'b0;
    @(negedge clk);
    total++; if (destino !== 3'b100) begin bad++; $display("FAIL order_mid_destino: got %b want 100", destino); end
    total++; if (pendientes !== 4'b0100) begin bad++; $display("FAIL order_mid_pend: got %b want 0100", pendientes); end
    wait_dispatch("order_dispatch_2", 10);
    ocupado = 1'b1;
    repeat (3) @(negedge clk);
    piso = 2'b10; ocupado = 1'b0;
    @(negedge clk);
    total++; if (destino !== 3'b110) begin bad++; $display("FAIL order_end_destino: got %b want 110", destino); end
    total++; if (pendientes !== 4'b0000) begin bad++; $display("FAIL order_end_pend: got %b want 0000", pendientes); end
  endtask

  task automatic test_duplicates();
    piso = 2'b01; ocupado = 1'b1;
    @(negedge clk);
    press(4'b0100);
    exp_q.push_back(3'b010);
    @(negedge clk);
    total++; if (cola_cuenta !== 3'd1) begin bad++; $display("FAIL dup_first_cuenta: got %0d want 1", cola_cuenta); end
    for (int k = 0; k < 2; k++) begin
      press(4'b0100);
      @(negedge clk);
      @(negedge clk);
      total++; if (cola_cuenta !== 3'd1) begin bad++; $display("FAIL dup_cuenta_%0d: got %0d want 1", k, cola_cuenta); end
      total++; if (pendientes !== 4'b0100) begin bad++; $display("FAIL dup_pend_%0d: got %b want 0100", k, pendientes); end
    end
    ocupado = 1'b0;
    wait_dispatch("dup_dispatch", 10);
    piso = 2'b10;
    @(negedge clk);
    total++; if (destino !== 3'b110) begin bad++; $display("FAIL dup_arrive_destino: got %b want 110", destino); end
    total++; if (pendientes !== 4'b0000) begin bad++; $display("FAIL dup_arrive_pend: got %b want 0000", pendientes); end
  endtask

  task automatic test_drop_at_floor();
    piso = 2'b10; ocupado = 1'b0;
    @(negedge clk);
    press(4'b0100);
    total++; if (pendientes !== 4'b0000) begin bad++; $display("FAIL drop_pend: got %b want 0000", pendientes); end
    @(negedge clk);
    total++; if (cola_cuenta !== 3'd0) begin bad++; $display("FAIL drop_cuenta: got %0d want 0", cola_cuenta); end
    @(negedge clk);
    total++; if (destino !== 3'b110) begin bad++; $display("FAIL drop_destino: got %b want 110", destino); end
  endtask

  task automatic test_stale();
    logic seen_dispatch = 1'b0;
    piso = 2'b10; ocupado = 1'b1;
    @(negedge clk);
    press(4'b0010);
    total++; if (pendientes !== 4'b0010) begin bad++; $display("FAIL stale_pend_set: got %b want 0010", pendientes); end
    @(negedge clk);
    total++; if (cola_cuenta !== 3'd1) begin bad++; $display("FAIL stale_cuenta_set: got %0d want 1", cola_cuenta); end
    piso = 2'b01; ocupado = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (destino[2] !== 1'b1) seen_dispatch = 1'b1;
    end
    total++; if (seen_dispatch !== 1'b0) begin bad++; $display("FAIL stale_no_dispatch: saw bit2=0, want always 1"); end
    total++; if (pendientes !== 4'b0000) begin bad++; $display("FAIL stale_pend_clr: got %b want 0000", pendientes); end
    total++; if (cola_cuenta !== 3'd0) begin bad++; $display("FAIL stale_cuenta_clr: got %0d want 0", cola_cuenta); end
    total++; if (destino !== 3'b101) begin bad++; $display("FAIL stale_destino: got %b want 101", destino); end
  endtask

  task automatic test_reset_mid_trip();
    logic seen_dispatch = 1'b0;
    piso = 2'b01; ocupado = 1'b0;
    press(4'b1000);
    exp_q.push_back(3'b011);
    wait_dispatch("rst_trip_dispatch", 10);
    ocupado = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (destino !== 3'b101) begin bad++; $display("FAIL rst_mid_destino: got %b want 101", destino); end
    total++; if (pendientes !== 4'b0000) begin bad++; $display("FAIL rst_mid_pend: got %b want 0000", pendientes); end
    total++; if (cola_cuenta !== 3'd0) begin bad++; $display("FAIL rst_mid_cuenta: got %0d want 0", cola_cuenta); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1; ocupado = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (destino[2] !== 1'b1) seen_dispatch = 1'b1;
    end
    total++; if (seen_dispatch !== 1'b0) begin bad++; $display("FAIL rst_post_dispatch: saw bit2=0 after reset"); end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_fifo_order();
    test_duplicates();
    test_drop_at_floor();
    test_stale();
    test_reset_mid_trip();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
